// File: rtl/write_full_if.sv
// write_full_if: write-side FIFO bundle; master drives the request and the
// synchronized read pointer, slave (write_full) returns pointers and flags.
interface write_full_if #(parameter int FIFO_DEPTH_BIT = 4);
  logic                      w_en;
  logic [FIFO_DEPTH_BIT:0]   read_addr_gray_sync;
  logic                      flag_full;
  logic                      flag_almost_full;
  logic                      flag_overflow;
  logic [FIFO_DEPTH_BIT-1:0] write_addr;
  logic [FIFO_DEPTH_BIT:0]   write_addr_gray;
  logic [FIFO_DEPTH_BIT:0]   w_level;
  modport master (
    output w_en, read_addr_gray_sync,
    input  flag_full, flag_almost_full, flag_overflow, write_addr, write_addr_gray, w_level
  );
  modport slave (
    input  w_en, read_addr_gray_sync,
    output flag_full, flag_almost_full, flag_overflow, write_addr, write_addr_gray, w_level
  );
endinterface

// File: rtl/write_full.sv
// write_full: async FIFO write pointer, registered Gray pointer, full/overflow flags.
// Optional WRITE_FULL_LEVEL_EN adds registered w_level and flag_almost_full.
module write_full #(
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int ALMOST_FULL_TH = 2
) (
  input  logic         w_clk,
  input  logic         w_rst_n,
  write_full_if.slave  bus
);
  localparam int N = FIFO_DEPTH_BIT;
  logic [N:0] bin_q, bin_d, gray_q, gray_d;
  logic       full_q, full_d, ovf_q, ovf_d, push;
  always_comb begin
    push   = bus.w_en && !full_q;
    bin_d  = bin_q + {{N{1'b0}}, push};
    gray_d = (bin_d >> 1) ^ bin_d;
    // full when the write pointer is one lap ahead: top two Gray bits inverted
    full_d = gray_d == {~bus.read_addr_gray_sync[N:N-1], bus.read_addr_gray_sync[N-2:0]};
    ovf_d  = ovf_q || (bus.w_en && full_q);
  end
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  assign bus.write_addr      = bin_q[N-1:0];
  assign bus.write_addr_gray = gray_q;
  assign bus.flag_full       = full_q;
  assign bus.flag_overflow   = ovf_q;
`ifdef WRITE_FULL_LEVEL_EN
  localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};
  logic [N:0] rbin, used, level_q, level_d;
  logic       afull_q, afull_d;
  for (genvar i = 0; i <= N; i++) begin : g_g2b
    assign rbin[i] = ^(bus.read_addr_gray_sync >> i);
  end
  always_comb begin
    used    = bin_d - rbin;
    level_d = used;
    afull_d = (DEPTH - used) <= (N+1)'(ALMOST_FULL_TH);
  end
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  assign bus.w_level          = level_q;
  assign bus.flag_almost_full = afull_q;
`else
  assign bus.w_level          = '0;
  assign bus.flag_almost_full = full_q;
`endif
endmodule

// File: tb/tb_write_full.sv
// tb_write_full: directed plan plus randomized push/read traffic checked
// against a pointer-count model of the FIFO occupancy.
module tb_write_full;
  localparam int N     = 4;
  localparam int DEPTH = 1 << N;
  localparam int MOD   = 2 * DEPTH;
  localparam int TH    = 2;
  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wptr, rptr, lvl_m;
  bit   full_m, ovf_m, saw_wrap;
  write_full_if #(.FIFO_DEPTH_BIT(N)) bus ();
  write_full #(.FIFO_DEPTH_BIT(N), .ALMOST_FULL_TH(TH)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .bus(bus.slave)
  );
  always #5 w_clk = ~w_clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction
  function automatic int occ();
    return (wptr - rptr + MOD) % MOD;
  endfunction
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    wptr = 0; rptr = 0; lvl_m = 0; full_m = 0; ovf_m = 0;
  endtask
  task automatic check_all();
    chk("write_addr", int'(bus.write_addr), wptr % DEPTH);
    chk("write_addr_gray", int'(bus.write_addr_gray), gray(wptr));
    chk("flag_full", int'(bus.flag_full), int'(full_m));
    chk("flag_overflow", int'(bus.flag_overflow), int'(ovf_m));
`ifdef WRITE_FULL_LEVEL_EN
    chk("w_level", int'(bus.w_level), lvl_m);
    chk("flag_almost_full", int'(bus.flag_almost_full), int'((DEPTH - lvl_m) <= TH));
`else
    chk("w_level", int'(bus.w_level), 0);
    chk("flag_almost_full", int'(bus.flag_almost_full), int'(full_m));
`endif
  endtask
  task automatic read_step();
    rptr = (rptr + 1) % MOD;
    bus.read_addr_gray_sync = (N+1)'(gray(rptr));
  endtask
  task automatic tick();
    bit push;
    push = bus.w_en && !full_m;
    if (bus.w_en && full_m) ovf_m = 1;
    @(posedge w_clk);
    wptr   = (wptr + int'(push)) % MOD;
    lvl_m  = occ();
    full_m = (lvl_m == DEPTH);
    @(negedge w_clk);
    check_all();
  endtask
  initial begin
    bus.w_en = 1'b1;
    bus.read_addr_gray_sync = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_gray", int'(bus.write_addr_gray), 0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    tick();
    chk("first_addr", int'(bus.write_addr), 1);
    chk("first_gray", int'(bus.write_addr_gray), 1);
    for (int i = 2; i <= DEPTH; i++) begin
      tick();
`ifdef WRITE_FULL_LEVEL_EN
      if (i == 13) begin
        chk("lvl13", int'(bus.w_level), 13);
        chk("afull13", int'(bus.flag_almost_full), 0);
      end
      if (i == 14) begin
        chk("lvl14", int'(bus.w_level), 14);
        chk("afull14", int'(bus.flag_almost_full), 1);
      end
`endif
    end
    chk("fill_full", int'(bus.flag_full), 1);
    chk("fill_gray", int'(bus.write_addr_gray), 24);
    chk("fill_addr", int'(bus.write_addr), 0);
    tick();
    chk("ovf_set", int'(bus.flag_overflow), 1);
    chk("ovf_gray_hold", int'(bus.write_addr_gray), 24);
    bus.w_en = 1'b0;
    tick();
    chk("ovf_sticky", int'(bus.flag_overflow), 1);
    rptr = 4;
    bus.read_addr_gray_sync = 5'b00110;
    tick();
    chk("drain_full", int'(bus.flag_full), 0);
    bus.w_en = 1'b1;
    repeat (4) tick();
    chk("refill_full", int'(bus.flag_full), 1);
    chk("refill_gray", int'(bus.write_addr_gray), 30);
    chk("refill_addr", int'(bus.write_addr), 4);
    bus.w_en = 1'b0;
    @(posedge w_clk);
    #1 w_rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("mid_rst_full", int'(bus.flag_full), 0);
    chk("mid_rst_ovf", int'(bus.flag_overflow), 0);
    bus.read_addr_gray_sync = '0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    bus.w_en = 1'b1;
    saw_wrap = 0;
    for (int i = 0; i < 60; i++) begin
      if (occ() > 0) read_step();
      if (wptr == MOD - 1) saw_wrap = 1;
      tick();
      chk("wrap_no_full", int'(bus.flag_full), 0);
    end
    chk("wrap_seen", int'(saw_wrap), 1);
    chk("wrap_no_ovf", int'(bus.flag_overflow), 0);
    for (int i = 0; i < 400; i++) begin
      bus.w_en = ($urandom % 4) != 0;
      if (occ() > 0 && ($urandom % 3) == 0) read_step();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_full.md
Name: write_full

Overview:
- Write-side pointer and full-flag generator for the async FIFO; the write-domain counterpart of the read-side empty logic.
- Keeps the binary write pointer, addresses the RAM write port, and exports a registered Gray pointer for synchronization into the read domain.
- Compares against the read Gray pointer that has already been synchronized into w_clk to produce a registered full flag and a sticky overflow error.
- The 2-FF synchronizer sits outside this block.

Parameters:
- FIFO_DEPTH_BIT, 4, log2 of FIFO depth (depth = 16); legal range >= 2.
- ALMOST_FULL_TH, 2, free-slot count at or below which flag_almost_full asserts (level option only).

Ports:
- w_clk  input  1  write-domain clock.
- w_rst_n  input  1  asynchronous reset, active-low.
- w_en  input  1  write request, one word per cycle.
- read_addr_gray_sync  input  FIFO_DEPTH_BIT+1  read Gray pointer, already synchronized to w_clk.
- flag_full  output  1  FIFO full; writes are ignored while high.
- flag_almost_full  output  1  free slots <= ALMOST_FULL_TH.
- flag_overflow  output  1  sticky: a write was attempted while full.
- write_addr  output  FIFO_DEPTH_BIT  RAM write address.
- write_addr_gray  output  FIFO_DEPTH_BIT+1  registered Gray write pointer, for CDC.
- w_level  output  FIFO_DEPTH_BIT+1  occupancy as seen from the write side.

Behaviour:
- Reset: any w_rst_n low asynchronously clears the internal binary pointer (N+1 bits) and all outputs to 0. This includes reset in mid-burst. Deassertion is synchronous to w_clk; it is synchronized outside this block.
- Push condition: push = w_en && !flag_full.
- Next pointer: next_bin = bin + push, computed modulo 2^(N+1), with natural wrap from all-ones to 0. Here N = FIFO_DEPTH_BIT.
- Gray conversion: next_gray = (next_bin >> 1) ^ next_bin.
- Registered outputs:
  - write_addr_gray is registered from next_gray. It is never decoded combinationally from bin, so it stays glitch-free across the CDC.
  - write_addr = bin[N-1:0]. The RAM write uses the current write_addr while push is high.
  - flag_full is registered as (next_gray == {~read_addr_gray_sync[N:N-1], read_addr_gray_sync[N-2:0]}).
- Full latency: the edge that accepts the last free word raises flag_full together with the pointer update, so there is zero dead cycles.
- Full is conservative: the synchronized read pointer lags the real one, so flag_full may stay high for up to 2–3 w_clk cycles after a read. This is required behaviour and is not an error.
- Full deassertion: flag_full drops on the first edge after read_addr_gray_sync changes to free a slot, provided no push happens on that edge.
- Write while full: w_en high with flag_full high leaves bin, write_addr and write_addr_gray unchanged, and sets flag_overflow. flag_overflow stays high until reset.
- Simultaneous read-side advance and push on the same edge: the comparison uses the current read_addr_gray_sync against next_gray. No special casing.
- read_addr_gray_sync is assumed to change by at most one Gray step per sample, which the upstream synchronizer guarantees. Multi-bit changes are undefined.

Optional Feature:
- Macro: WRITE_FULL_LEVEL_EN.
- Defined:
  - read_addr_gray_sync is converted Gray-to-binary (prefix XOR from the MSB down) to give rbin.
  - w_level is registered from (next_bin - rbin) modulo 2^(N+1). Its range is 0..2^N.
  - flag_almost_full is registered from ((2^N - (next_bin - rbin)) <= ALMOST_FULL_TH).
  - Both reset to 0 and update on the same edge as flag_full.
- Undefined:
  - No Gray-to-binary logic is built.
  - w_level is tied to 0.
  - flag_almost_full is a wire copy of flag_full.
  - Ports are identical in both builds.

Test Plan:
- Reset: w_rst_n=0 while driving w_en=1 -> write_addr=0, write_addr_gray=5'b00000, flag_full=0, flag_overflow=0, w_level=0. Release, then 1 push -> write_addr=1, write_addr_gray=5'b00001.
- Fill: read_addr_gray_sync=0, w_en=1 for 16 cycles -> after the 16th edge flag_full=1, write_addr=0, write_addr_gray=5'b11000. A 17th w_en -> pointer unchanged, flag_overflow=1 and it stays 1 after w_en drops.
- Drain step: from full, set read_addr_gray_sync=gray(4)=5'b00110 -> flag_full=0 on the next edge. 4 more pushes -> flag_full=1 with write_addr_gray=5'b11110, write_addr=4.
- Wrap: track reads so the FIFO never fills and push 40 words -> write_addr_gray passes 5'b10000 (bin 31) -> 5'b00000 (bin 0); flag_full never asserts; flag_overflow=0.
- Mid-operation reset: pulse w_rst_n low for half a cycle while full with flag_overflow=1 -> all outputs 0 immediately, without waiting for w_clk.
- WRITE_FULL_LEVEL_EN: read_addr_gray_sync=0, 13 pushes -> w_level=13, flag_almost_full=0. 14th push -> w_level=14, flag_almost_full=1. Build without the macro -> w_level=0 and flag_almost_full tracks flag_full.
